// File: rtl/bank_refill_isu.sv
// bank_refill_isu: refill issue stage between the bank BIU and the bank SRAM.
// Buffers tagged 256-bit refill lines in a small FIFO, writes each line into
// the SRAM as two 128-bit beats addressed by {set_way, beat}, and pulses a
// refill-done indication toward the hit-test unit once the second beat lands.
//
// Beat sequencer states:
//   state   | meaning
//   BEAT_LO | head line's low half is (or will be) presented, offset 0
//   BEAT_HI | low half accepted; high half presented, offset 1
module bank_refill_isu #(
  parameter int DATA_WIDTH = 256,
  parameter int SRAM_WIDTH = 128,
  parameter int ID_WIDTH   = 6,
  parameter int DEPTH      = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         biu_isu_rvalid_i,
  output logic                         biu_isu_rready_o,
  input  logic [DATA_WIDTH-1:0]        biu_isu_rdata_i,
  input  logic [ID_WIDTH-1:0]          biu_isu_rid_i,
  output logic                         isu_sram_wvalid_o,
  input  logic                         isu_sram_wready_i,
  output logic [SRAM_WIDTH-1:0]        isu_sram_wdata_o,
  output logic [ID_WIDTH:0]            isu_sram_set_way_offset_o,
  output logic                         isu_htu_done_valid_o,
  output logic [ID_WIDTH-1:0]          isu_htu_done_id_o,
  output logic [$clog2(DEPTH):0]       isu_level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic {
    BEAT_LO = 1'b0,
    BEAT_HI = 1'b1
  } beat_e;

  logic [DATA_WIDTH-1:0] line_data [DEPTH];
  logic [ID_WIDTH-1:0]   line_id   [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  beat_e                 beat;
  logic                  done_valid;
  logic [ID_WIDTH-1:0]   done_id;

  logic push;
  logic beat_fire;
  logic pop;

  // Ready/valid come straight from the registered occupancy so that a full
  // buffer never depends on the SRAM side in the same cycle.
  assign biu_isu_rready_o  = (count != FULL);
  assign isu_sram_wvalid_o = (count != '0);

  assign push      = biu_isu_rvalid_i & biu_isu_rready_o;
  assign beat_fire = isu_sram_wvalid_o & isu_sram_wready_i;
  assign pop       = beat_fire & (beat == BEAT_HI);

  // Head-of-line beat selection; everything here is a function of registers
  // only, so the beat stays stable while the SRAM stalls.
  assign isu_sram_wdata_o = (beat == BEAT_HI)
                          ? line_data[rd_ptr][DATA_WIDTH-1:SRAM_WIDTH]
                          : line_data[rd_ptr][SRAM_WIDTH-1:0];
  assign isu_sram_set_way_offset_o = {line_id[rd_ptr], logic'(beat)};

  assign isu_htu_done_valid_o = done_valid;
  assign isu_htu_done_id_o    = done_id;
  assign isu_level_o          = count;

  // Line buffer storage: written at the tail on every accepted refill line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        line_data[i] <= '0;
        line_id[i]   <= '0;
      end
    end else if (push) begin
      line_data[wr_ptr] <= biu_isu_rdata_i;
      line_id[wr_ptr]   <= biu_isu_rid_i;
    end
  end

  // Pointers, occupancy, beat sequencer and the registered done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      beat       <= BEAT_LO;
      done_valid <= 1'b0;
      done_id    <= '0;
    end else begin
      done_valid <= 1'b0;

      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (beat)
        BEAT_LO: begin
          if (beat_fire) begin
            beat <= BEAT_HI;
          end
        end
        BEAT_HI: begin
          if (beat_fire) begin
            beat       <= BEAT_LO;
            rd_ptr     <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            done_valid <= 1'b1;
            done_id    <= line_id[rd_ptr];
          end
        end
        default: beat <= BEAT_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_bank_refill_isu.sv
// Self-checking bench for bank_refill_isu: directed scenarios plus a random
// traffic phase, checked against a line-level queue model.
module tb_bank_refill_isu;

  localparam int DW    = 256;
  localparam int SW    = 128;
  localparam int IW    = 6;
  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [IW-1:0] rid;
  logic          wvalid;
  logic          wready;
  logic [SW-1:0] wdata;
  logic [IW:0]   off;
  logic          done_valid;
  logic [IW-1:0] done_id;
  logic [LW-1:0] level;

  bank_refill_isu #(
    .DATA_WIDTH(DW), .SRAM_WIDTH(SW), .ID_WIDTH(IW), .DEPTH(DEPTH)
  ) dut (
    .clk_i                     (clk),
    .rst_i                     (rst),
    .biu_isu_rvalid_i          (rvalid),
    .biu_isu_rready_o          (rready),
    .biu_isu_rdata_i           (rdata),
    .biu_isu_rid_i             (rid),
    .isu_sram_wvalid_o         (wvalid),
    .isu_sram_wready_i         (wready),
    .isu_sram_wdata_o          (wdata),
    .isu_sram_set_way_offset_o (off),
    .isu_htu_done_valid_o      (done_valid),
    .isu_htu_done_id_o         (done_id),
    .isu_level_o               (level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] rid;
    logic [DW-1:0] data;
  } line_t;

  typedef struct packed {
    logic [SW-1:0] data;
    logic [IW:0]   off;
  } beat_t;

  int errors = 0;
  int checks = 0;

  line_t         acc_q[$];
  beat_t         got_beats[$];
  logic [IW-1:0] got_done[$];
  beat_t         exp_beats[$];
  logic [IW-1:0] exp_done[$];
  int            n_acc = 0;
  int            n_pop = 0;
  bit            phase = 0;

  // Observe handshakes mid-cycle; they take effect at the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      n_acc = 0;
      n_pop = 0;
      phase = 0;
    end else begin
      if (rvalid && rready) begin
        acc_q.push_back('{rid: rid, data: rdata});
        n_acc++;
      end
      if (wvalid && wready) begin
        got_beats.push_back('{data: wdata, off: off});
        if (phase) n_pop++;
        phase = ~phase;
      end
      if (done_valid) got_done.push_back(done_id);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Every accepted line must come out as low half (offset 0), high half
  // (offset 1), then one done carrying its ID, all in arrival order.
  function automatic void model_build();
    exp_beats.delete();
    exp_done.delete();
    foreach (acc_q[i]) begin
      exp_beats.push_back('{data: acc_q[i].data[SW-1:0],  off: {acc_q[i].rid, 1'b0}});
      exp_beats.push_back('{data: acc_q[i].data[DW-1:SW], off: {acc_q[i].rid, 1'b1}});
      exp_done.push_back(acc_q[i].rid);
    end
  endfunction

  function automatic void clear_model();
    acc_q.delete();
    got_beats.delete();
    got_done.delete();
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while ((wvalid || done_valid) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s drain timeout: wvalid=%0b level=%0d", name, wvalid, level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks += 7;
    if (rready !== 1'b1)  begin errors++; $display("FAIL reset rready got=%b exp=1", rready); end
    if (wvalid !== 1'b0)  begin errors++; $display("FAIL reset wvalid got=%b exp=0", wvalid); end
    if (wdata !== '0)     begin errors++; $display("FAIL reset wdata got=%h exp=0", wdata); end
    if (off !== '0)       begin errors++; $display("FAIL reset offset got=%h exp=0", off); end
    if (done_valid !== 1'b0) begin errors++; $display("FAIL reset done_valid got=%b exp=0", done_valid); end
    if (done_id !== '0)   begin errors++; $display("FAIL reset done_id got=%h exp=0", done_id); end
    if (level !== '0)     begin errors++; $display("FAIL reset level got=%0d exp=0", level); end
    rst = 1'b0;
    tick();
    checks += 2;
    if (rready !== 1'b1 || wvalid !== 1'b0)
      begin errors++; $display("FAIL post_reset rready/wvalid got=%b/%b exp=1/0", rready, wvalid); end
    if (level !== '0) begin errors++; $display("FAIL post_reset level got=%0d exp=0", level); end
  endtask

  task automatic test_single();
    logic [SW-1:0] a = {32{4'hA}};
    logic [SW-1:0] b = {32{4'hB}};
    clear_model();
    wready = 1'b1;
    rid    = 6'h15;
    rdata  = {b, a};
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    checks += 4;
    if (wvalid !== 1'b1) begin errors++; $display("FAIL single beat0 wvalid got=%b exp=1", wvalid); end
    if (wdata !== a)     begin errors++; $display("FAIL single beat0 wdata got=%h exp=%h", wdata, a); end
    if (off !== 7'h2A)   begin errors++; $display("FAIL single beat0 offset got=%h exp=2a", off); end
    if (level !== 1)     begin errors++; $display("FAIL single level got=%0d exp=1", level); end
    tick();
    checks += 3;
    if (wdata !== b)     begin errors++; $display("FAIL single beat1 wdata got=%h exp=%h", wdata, b); end
    if (off !== 7'h2B)   begin errors++; $display("FAIL single beat1 offset got=%h exp=2b", off); end
    if (done_valid !== 1'b0) begin errors++; $display("FAIL single early done got=%b exp=0", done_valid); end
    tick();
    checks += 3;
    if (done_valid !== 1'b1) begin errors++; $display("FAIL single done_valid got=%b exp=1", done_valid); end
    if (done_id !== 6'h15)   begin errors++; $display("FAIL single done_id got=%h exp=15", done_id); end
    if (wvalid !== 1'b0)     begin errors++; $display("FAIL single idle wvalid got=%b exp=0", wvalid); end
    tick();
    checks += 2;
    if (done_valid !== 1'b0) begin errors++; $display("FAIL single done width got=%b exp=0", done_valid); end
    if (done_id !== 6'h15)   begin errors++; $display("FAIL single done_id hold got=%h exp=15", done_id); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] d  = rand_line();
    logic [IW-1:0] id = IW'($urandom);
    clear_model();
    wready = 1'b0;
    rid    = id;
    rdata  = d;
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks += 4;
      if (wvalid !== 1'b1) begin errors++; $display("FAIL stall wvalid c%0d got=%b exp=1", c, wvalid); end
      if (wdata !== d[SW-1:0]) begin errors++; $display("FAIL stall wdata c%0d got=%h exp=%h", c, wdata, d[SW-1:0]); end
      if (off !== {id, 1'b0}) begin errors++; $display("FAIL stall offset c%0d got=%h exp=%h", c, off, {id, 1'b0}); end
      if (done_valid !== 1'b0) begin errors++; $display("FAIL stall done c%0d got=%b exp=0", c, done_valid); end
      tick();
    end
    wready = 1'b1;
    wait_idle("stall");
    model_build();
    checks++;
    if (got_beats.size() != exp_beats.size() || got_done.size() != exp_done.size())
      begin errors++; $display("FAIL stall counts beats got=%0d exp=%0d done got=%0d exp=%0d",
                               got_beats.size(), exp_beats.size(), got_done.size(), exp_done.size()); end
    for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
      checks++;
      if (got_beats[i] !== exp_beats[i])
        begin errors++; $display("FAIL stall beat%0d got off=%h data=%h exp off=%h data=%h",
                                 i, got_beats[i].off, got_beats[i].data, exp_beats[i].off, exp_beats[i].data); end
    end
    for (int i = 0; i < exp_done.size() && i < got_done.size(); i++) begin
      checks++;
      if (got_done[i] !== exp_done[i])
        begin errors++; $display("FAIL stall done%0d got=%h exp=%h", i, got_done[i], exp_done[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    clear_model();
    wready = 1'b0;
    rvalid = 1'b1;
    rid    = 6'd1;
    rdata  = rand_line();
    tick();
    checks++;
    if (level !== 1) begin errors++; $display("FAIL b2b level1 got=%0d exp=1", level); end
    rid   = 6'd2;
    rdata = rand_line();
    tick();
    rid   = 6'd3;
    rdata = rand_line();
    checks += 2;
    if (level !== 2)     begin errors++; $display("FAIL b2b level2 got=%0d exp=2", level); end
    if (rready !== 1'b0) begin errors++; $display("FAIL b2b full rready got=%b exp=0", rready); end
    tick();
    tick();
    checks += 3;
    if (level !== 2)     begin errors++; $display("FAIL b2b held level got=%0d exp=2", level); end
    if (rready !== 1'b0) begin errors++; $display("FAIL b2b held rready got=%b exp=0", rready); end
    if (off !== {6'd1, 1'b0}) begin errors++; $display("FAIL b2b head offset got=%h exp=02", off); end
    wready = 1'b1;
    while (acc_q.size() < 3 && n < 20) begin
      tick();
      n++;
    end
    rvalid = 1'b0;
    if (n >= 20) begin checks++; errors++; $display("FAIL b2b third line never accepted"); end
    wait_idle("b2b");
    model_build();
    checks++;
    if (got_beats.size() != 6 || got_done.size() != 3)
      begin errors++; $display("FAIL b2b counts beats got=%0d exp=6 done got=%0d exp=3",
                               got_beats.size(), got_done.size()); end
    for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
      checks++;
      if (got_beats[i] !== exp_beats[i])
        begin errors++; $display("FAIL b2b beat%0d got off=%h data=%h exp off=%h data=%h",
                                 i, got_beats[i].off, got_beats[i].data, exp_beats[i].off, exp_beats[i].data); end
    end
    for (int i = 0; i < 3 && i < got_done.size(); i++) begin
      checks++;
      if (got_done[i] !== IW'(i + 1))
        begin errors++; $display("FAIL b2b done%0d got=%h exp=%h", i, got_done[i], IW'(i + 1)); end
    end
  endtask

  task automatic test_same_cycle();
    clear_model();
    wready = 1'b1;
    for (int l = 0; l < 6; l++) begin
      rvalid = 1'b1;
      rid    = IW'($urandom);
      rdata  = rand_line();
      tick();
      rvalid = 1'b0;
      checks++;
      if (level !== 1) begin errors++; $display("FAIL same_cycle push%0d level got=%0d exp=1", l, level); end
      tick();
      checks++;
      if (level !== 1) begin errors++; $display("FAIL same_cycle beat%0d level got=%0d exp=1", l, level); end
    end
    wait_idle("same_cycle");
    model_build();
    checks++;
    if (got_beats.size() != 12 || got_done.size() != 6)
      begin errors++; $display("FAIL same_cycle counts beats got=%0d exp=12 done got=%0d exp=6",
                               got_beats.size(), got_done.size()); end
    for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
      checks++;
      if (got_beats[i] !== exp_beats[i])
        begin errors++; $display("FAIL same_cycle beat%0d got off=%h data=%h exp off=%h data=%h",
                                 i, got_beats[i].off, got_beats[i].data, exp_beats[i].off, exp_beats[i].data); end
    end
    for (int i = 0; i < exp_done.size() && i < got_done.size(); i++) begin
      checks++;
      if (got_done[i] !== exp_done[i])
        begin errors++; $display("FAIL same_cycle done%0d got=%h exp=%h", i, got_done[i], exp_done[i]); end
    end
  endtask

  task automatic test_random();
    int exp_level;
    clear_model();
    for (int c = 0; c < 400; c++) begin
      rvalid = 1'($urandom_range(0, 1));
      rid    = IW'($urandom);
      rdata  = rand_line();
      wready = ($urandom_range(0, 3) != 0);
      tick();
      exp_level = n_acc - n_pop;
      checks += 3;
      if (level !== LW'(exp_level))
        begin errors++; $display("FAIL random level c%0d got=%0d exp=%0d", c, level, exp_level); end
      if (rready !== (exp_level != DEPTH))
        begin errors++; $display("FAIL random rready c%0d got=%b exp=%b", c, rready, exp_level != DEPTH); end
      if (wvalid !== (exp_level != 0))
        begin errors++; $display("FAIL random wvalid c%0d got=%b exp=%b", c, wvalid, exp_level != 0); end
    end
    rvalid = 1'b0;
    wready = 1'b1;
    wait_idle("random");
    model_build();
    checks++;
    if (got_beats.size() != exp_beats.size() || got_done.size() != exp_done.size())
      begin errors++; $display("FAIL random counts beats got=%0d exp=%0d done got=%0d exp=%0d",
                               got_beats.size(), exp_beats.size(), got_done.size(), exp_done.size()); end
    for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
      checks++;
      if (got_beats[i] !== exp_beats[i])
        begin errors++; $display("FAIL random beat%0d got off=%h data=%h exp off=%h data=%h",
                                 i, got_beats[i].off, got_beats[i].data, exp_beats[i].off, exp_beats[i].data); end
    end
    for (int i = 0; i < exp_done.size() && i < got_done.size(); i++) begin
      checks++;
      if (got_done[i] !== exp_done[i])
        begin errors++; $display("FAIL random done%0d got=%h exp=%h", i, got_done[i], exp_done[i]); end
    end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] d;
    logic [IW-1:0] id;
    clear_model();
    wready = 1'b1;
    rvalid = 1'b1;
    rid    = IW'($urandom);
    rdata  = rand_line();
    tick();
    rvalid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks += 6;
    if (wvalid !== 1'b0) begin errors++; $display("FAIL mid_reset wvalid got=%b exp=0", wvalid); end
    if (off !== '0)      begin errors++; $display("FAIL mid_reset offset got=%h exp=0", off); end
    if (wdata !== '0)    begin errors++; $display("FAIL mid_reset wdata got=%h exp=0", wdata); end
    if (level !== '0)    begin errors++; $display("FAIL mid_reset level got=%0d exp=0", level); end
    if (rready !== 1'b1) begin errors++; $display("FAIL mid_reset rready got=%b exp=1", rready); end
    if (done_valid !== 1'b0) begin errors++; $display("FAIL mid_reset done got=%b exp=0", done_valid); end
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (got_done.size() != 0) begin errors++; $display("FAIL mid_reset spurious done count got=%0d exp=0", got_done.size()); end
    clear_model();
    d      = rand_line();
    id     = IW'($urandom);
    rvalid = 1'b1;
    rid    = id;
    rdata  = d;
    tick();
    rvalid = 1'b0;
    checks += 2;
    if (off !== {id, 1'b0}) begin errors++; $display("FAIL mid_reset restart offset got=%h exp=%h", off, {id, 1'b0}); end
    if (wdata !== d[SW-1:0]) begin errors++; $display("FAIL mid_reset restart wdata got=%h exp=%h", wdata, d[SW-1:0]); end
    wait_idle("mid_reset");
    model_build();
    checks++;
    if (got_beats.size() != 2 || got_done.size() != 1)
      begin errors++; $display("FAIL mid_reset counts beats got=%0d exp=2 done got=%0d exp=1",
                               got_beats.size(), got_done.size()); end
    for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
      checks++;
      if (got_beats[i] !== exp_beats[i])
        begin errors++; $display("FAIL mid_reset beat%0d got off=%h exp off=%h", i, got_beats[i].off, exp_beats[i].off); end
    end
    if (got_done.size() > 0) begin
      checks++;
      if (got_done[0] !== id) begin errors++; $display("FAIL mid_reset done_id got=%h exp=%h", got_done[0], id); end
    end
  endtask

  initial begin
    rst    = 1'b1;
    rvalid = 1'b0;
    rdata  = '0;
    rid    = '0;
    wready = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_same_cycle();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bank_refill_isu.md
Name: bank_refill_isu

Overview:
- Refill issue stage directly downstream of the bank bus interface unit.
- Accepts full 256-bit refill lines tagged with a 6-bit set/way ID from the BIU and buffers them in a small FIFO.
- Splits each line into two 128-bit beats and writes them into the bank SRAM using {set_way, offset} addressing.
- Emits a one-cycle refill-done pulse per completed line back to the hit-test unit (HTU).

Parameters:
DATA_WIDTH, 256, refill line width; must be 2*SRAM_WIDTH
SRAM_WIDTH, 128, SRAM write port width
ID_WIDTH, 6, set/way identifier width
DEPTH, 2, line-buffer entries; power of two, >=2

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
biu_isu_rvalid_i  input  1  refill line valid
biu_isu_rready_o  output  1  refill line ready
biu_isu_rdata_i  input  DATA_WIDTH  refill line data
biu_isu_rid_i  input  ID_WIDTH  refill line set/way
isu_sram_wvalid_o  output  1  SRAM write beat valid
isu_sram_wready_i  input  1  SRAM write beat ready
isu_sram_wdata_o  output  SRAM_WIDTH  write beat data
isu_sram_set_way_offset_o  output  ID_WIDTH+1  {set_way, beat offset}
isu_htu_done_valid_o  output  1  line refill complete pulse; no backpressure
isu_htu_done_id_o  output  ID_WIDTH  set/way of completed line
isu_level_o  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_i high):
  - wr_ptr, rd_ptr, count, beat and done registers clear to 0; buffer entries clear to 0.
  - Output values during and after reset until first fill: rready_o=1, wvalid_o=0, wdata_o=0, set_way_offset_o=0, done_valid_o=0, done_id_o=0, level_o=0.
- Enqueue:
  - biu_isu_rready_o = (count != DEPTH). Registered count only; no same-cycle pop-through when full.
  - Push when rvalid_i & rready_o: entry[wr_ptr] <= {rid, rdata}; wr_ptr wraps modulo DEPTH.
- Drain:
  - isu_sram_wvalid_o = (count != 0).
  - Head entry is entry[rd_ptr]. beat 0 sends rdata[SRAM_WIDTH-1:0] with offset 0; beat 1 sends rdata[DATA_WIDTH-1:SRAM_WIDTH] with offset 1.
  - isu_sram_set_way_offset_o = {head.rid, beat}.
  - Outputs hold stable while wvalid_o=1 and wready_i=0 (AXI-style; valid never drops without a handshake).
  - Handshake on beat 0: beat <= 1.
  - Handshake on beat 1: beat <= 0, pop (rd_ptr wraps modulo DEPTH), done_valid_o <= 1 and done_id_o <= head.rid on the next edge.
  - done_valid_o is a single-cycle pulse; otherwise 0. done_id_o holds its last value.
- Latency:
  - Line accepted at edge N -> beat 0 wvalid at cycle N+1.
  - With wready stuck at 1: beat 1 at N+2, done pulse at N+3.
  - Steady-state throughput with wready=1: one line per 2 cycles.
- Count: simultaneous push and pop leaves count unchanged; push alone +1; pop alone -1. Push when full or pop when empty is impossible by construction.
- Wrap-around: pointers wrap DEPTH-1 -> 0. FIFO order strictly preserved; IDs are never reordered.
- Mid-operation reset: async reset discards all buffered lines and any partial beat. No done pulse is issued for the discarded lines.
- isu_level_o = count (registered).

Test Plan:
- Single line rid=6'h15, rdata={128'hB..B, 128'hA..A}, wready=1 -> beat 128'hA..A with offset 7'h2A, then 128'hB..B with offset 7'h2B, then done_valid=1 and done_id=6'h15 for exactly 1 cycle.
- wready held 0 for 5 cycles on beat 0 -> wvalid stays 1; wdata and offset stable; no done pulse; then release -> normal completion.
- Back-to-back lines IDs 1,2,3 with wready=0 -> rready_o drops after 2 pushes and level_o=2; after release, beats appear in order 1,1,2,2,3,3 and done pulses 1,2,3.
- Push and pop in the same cycle at level 1 -> level stays 1; pointers wrap correctly over 6 lines; no data loss.
- Assert rst_i after beat 0 handshake of a line -> all outputs return to reset values immediately; no done pulse; next line starts at offset 0.
